// File: rtl/branch_resolver.sv
// ID-stage branch resolution unit.
// Registers the BTB prediction made for the delay-slot fetch and computes the real
// next PC when the branch reaches ID. On a mismatch it redirects fetch, flushes IF
// and writes the corrected target back into the BTB. It also keeps saturating
// branch and mispredict counters for board debug.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   stall                    hazard-unit hold; IF/ID frozen
//   if_valid/if_pc/if_pred_pc  current fetch and its BTB prediction
//   id_br_type               000 none, 001 B, 010 BEQZ, 011 BNEZ, 100 JR, others none
//   id_offset                sign-extended branch offset
//   id_rs_val/id_rs_ready    forwarded rs operand and its ready flag
//   hold_id                  combinational freeze request while waiting for rs
//   redirect/redirect_pc     one-cycle fetch redirect and correct next PC
//   flush_if                 kill the wrongly fetched instruction (with redirect)
//   btb_upd_n/btb_from/btb_to  active-low BTB write strobe, index PC, target PC
//   cnt_branch/cnt_mispred   saturating performance counters
module branch_resolver #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic [PC_W-1:0]  if_pred_pc,
    input  logic [2:0]       id_br_type,
    input  logic [PC_W-1:0]  id_offset,
    input  logic [PC_W-1:0]  id_rs_val,
    input  logic             id_rs_ready,
    output logic             hold_id,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             btb_upd_n,
    output logic [PC_W-1:0]  btb_from,
    output logic [PC_W-1:0]  btb_to,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [2:0] BR_B    = 3'b001;
    localparam logic [2:0] BR_BEQZ = 3'b010;
    localparam logic [2:0] BR_BNEZ = 3'b011;
    localparam logic [2:0] BR_JR   = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_OP = 2'b01,
        RECOVER = 2'b10
    } state_t;

    state_t          state;
    logic [PC_W-1:0] s_pc;
    logic [PC_W-1:0] s_pred;
    logic            s_vld;

    logic            is_br;
    logic            needs_rs;
    logic            rs_zero;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] fall_thru;
    logic [PC_W-1:0] actual;
    logic            resolve;
    logic            mispred;
    logic            go_wait;

    // Branch decode and actual next-PC computation (wraps modulo 2^PC_W).
    always_comb begin
        needs_rs  = 1'b0;
        is_br     = 1'b0;
        rs_zero   = (id_rs_val == '0);
        target    = s_pc + id_offset;
        fall_thru = s_pc + PC_W'(PC_STEP);
        actual    = fall_thru;
        unique case (id_br_type)
            BR_B: begin
                is_br  = s_vld;
                actual = target;
            end
            BR_BEQZ: begin
                is_br    = s_vld;
                needs_rs = 1'b1;
                actual   = rs_zero ? target : fall_thru;
            end
            BR_BNEZ: begin
                is_br    = s_vld;
                needs_rs = 1'b1;
                actual   = rs_zero ? fall_thru : target;
            end
            BR_JR: begin
                is_br    = s_vld;
                needs_rs = 1'b1;
                actual   = id_rs_val;
            end
            default: begin
                is_br    = 1'b0;
                needs_rs = 1'b0;
            end
        endcase
    end

    // Resolution control; RECOVER never resolves because ID still holds the delay slot.
    always_comb begin
        hold_id = 1'b0;
        resolve = 1'b0;
        go_wait = 1'b0;
        unique case (state)
            IDLE: begin
                if (!stall && is_br) begin
                    if (needs_rs && !id_rs_ready) begin
                        hold_id = 1'b1;
                        go_wait = 1'b1;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            WAIT_OP: begin
                hold_id = !id_rs_ready;
                // A stalled pipeline keeps the branch pending so it resolves exactly once.
                resolve = id_rs_ready && !stall;
            end
            default: begin
                hold_id = 1'b0;
                resolve = 1'b0;
            end
        endcase
        mispred = resolve && (actual != s_pred);
    end

    // Delay-slot prediction register; a flush always kills the captured slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pc   <= '0;
            s_pred <= '0;
            s_vld  <= 1'b0;
        end else if (flush_if) begin
            s_vld  <= 1'b0;
        end else if (!stall && !hold_id) begin
            s_pc   <= if_pc;
            s_pred <= if_pred_pc;
            s_vld  <= if_valid;
        end
    end

    // State, registered strobes/payloads and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            redirect    <= 1'b0;
            flush_if    <= 1'b0;
            btb_upd_n   <= 1'b1;
            redirect_pc <= '0;
            btb_from    <= '0;
            btb_to      <= '0;
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else begin
            redirect  <= 1'b0;
            flush_if  <= 1'b0;
            btb_upd_n <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (go_wait) begin
                        state <= WAIT_OP;
                    end else if (mispred) begin
                        state <= RECOVER;
                    end
                end
                WAIT_OP: begin
                    if (resolve) begin
                        state <= mispred ? RECOVER : IDLE;
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (mispred) begin
                redirect    <= 1'b1;
                flush_if    <= 1'b1;
                btb_upd_n   <= 1'b0;
                redirect_pc <= actual;
                btb_from    <= s_pc;
                btb_to      <= actual;
            end

            if (resolve && (cnt_branch != {CNT_W{1'b1}})) begin
                cnt_branch <= cnt_branch + CNT_W'(1);
            end
            if (mispred && (cnt_mispred != {CNT_W{1'b1}})) begin
                cnt_mispred <= cnt_mispred + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_B    = 3'b001;
    localparam logic [2:0] BR_BEQZ = 3'b010;
    localparam logic [2:0] BR_BNEZ = 3'b011;
    localparam logic [2:0] BR_JR   = 3'b100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_pred_pc;
    logic [2:0]  id_br_type;
    logic [15:0] id_offset;
    logic [15:0] id_rs_val;
    logic        id_rs_ready;
    logic        hold_id;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush_if;
    logic        btb_upd_n;
    logic [15:0] btb_from;
    logic [15:0] btb_to;
    logic [15:0] cnt_branch;
    logic [15:0] cnt_mispred;

    // Narrow-counter copy driven by the same stimulus, used to reach saturation quickly.
    logic        sat_hold_id;
    logic        sat_redirect;
    logic [15:0] sat_redirect_pc;
    logic        sat_flush_if;
    logic        sat_btb_upd_n;
    logic [15:0] sat_btb_from;
    logic [15:0] sat_btb_to;
    logic [2:0]  sat_cnt_branch;
    logic [2:0]  sat_cnt_mispred;

    int passed;
    int total;

    branch_resolver dut (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_pc(if_pred_pc), .id_br_type(id_br_type), .id_offset(id_offset),
        .id_rs_val(id_rs_val), .id_rs_ready(id_rs_ready), .hold_id(hold_id),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush_if(flush_if),
        .btb_upd_n(btb_upd_n), .btb_from(btb_from), .btb_to(btb_to),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    branch_resolver #(.PC_W(16), .PC_STEP(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
        .if_pred_pc(if_pred_pc), .id_br_type(id_br_type), .id_offset(id_offset),
        .id_rs_val(id_rs_val), .id_rs_ready(id_rs_ready), .hold_id(sat_hold_id),
        .redirect(sat_redirect), .redirect_pc(sat_redirect_pc), .flush_if(sat_flush_if),
        .btb_upd_n(sat_btb_upd_n), .btb_from(sat_btb_from), .btb_to(sat_btb_to),
        .cnt_branch(sat_cnt_branch), .cnt_mispred(sat_cnt_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Capture one delay-slot fetch into the resolver, then stop presenting valid fetches.
    task automatic load_slot(input logic [15:0] pc, input logic [15:0] pred);
        if_valid   = 1'b1;
        if_pc      = pc;
        if_pred_pc = pred;
        id_br_type = BR_NONE;
        cyc();
        if_valid   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL rst_redirect got %h exp 0", redirect); else passed++;
        total++; if (flush_if !== 1'b0) $display("FAIL rst_flush got %h exp 0", flush_if); else passed++;
        total++; if (hold_id !== 1'b0) $display("FAIL rst_hold got %h exp 0", hold_id); else passed++;
        total++; if (btb_upd_n !== 1'b1) $display("FAIL rst_btb_upd_n got %h exp 1", btb_upd_n); else passed++;
        total++; if ({redirect_pc, btb_from, btb_to} !== 48'h0) $display("FAIL rst_payload got %h exp 0", {redirect_pc, btb_from, btb_to}); else passed++;
        total++; if ({cnt_branch, cnt_mispred} !== 32'h0) $display("FAIL rst_counters got %h exp 0", {cnt_branch, cnt_mispred}); else passed++;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_b_match();
        load_slot(16'h0010, 16'h0018);
        id_br_type = BR_B;
        id_offset  = 16'h0008;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL bmatch_redirect got %h exp 0", redirect); else passed++;
        total++; if (btb_upd_n !== 1'b1) $display("FAIL bmatch_btb_upd_n got %h exp 1", btb_upd_n); else passed++;
        total++; if (cnt_branch !== 16'd1) $display("FAIL bmatch_cnt_branch got %0d exp 1", cnt_branch); else passed++;
        total++; if (cnt_mispred !== 16'd0) $display("FAIL bmatch_cnt_mispred got %0d exp 0", cnt_mispred); else passed++;
        cyc();
    endtask

    task automatic test_b_mispredict();
        load_slot(16'h0010, 16'h0014);
        id_br_type = BR_B;
        id_offset  = 16'h0008;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect !== 1'b1) $display("FAIL bmp_redirect got %h exp 1", redirect); else passed++;
        total++; if (flush_if !== 1'b1) $display("FAIL bmp_flush got %h exp 1", flush_if); else passed++;
        total++; if (redirect_pc !== 16'h0018) $display("FAIL bmp_redirect_pc got %h exp 0018", redirect_pc); else passed++;
        total++; if (btb_upd_n !== 1'b0) $display("FAIL bmp_btb_upd_n got %h exp 0", btb_upd_n); else passed++;
        total++; if (btb_from !== 16'h0010) $display("FAIL bmp_btb_from got %h exp 0010", btb_from); else passed++;
        total++; if (btb_to !== 16'h0018) $display("FAIL bmp_btb_to got %h exp 0018", btb_to); else passed++;
        total++; if (cnt_mispred !== 16'd1) $display("FAIL bmp_cnt_mispred got %0d exp 1", cnt_mispred); else passed++;
        total++; if (cnt_branch !== 16'd2) $display("FAIL bmp_cnt_branch got %0d exp 2", cnt_branch); else passed++;
        cyc();
        total++; if ({redirect, flush_if, btb_upd_n} !== 3'b001) $display("FAIL bmp_pulse_end got %b exp 001", {redirect, flush_if, btb_upd_n}); else passed++;
    endtask

    task automatic test_beqz_recover();
        load_slot(16'h0020, 16'h0030);
        id_br_type  = BR_BEQZ;
        id_offset   = 16'h0010;
        id_rs_val   = 16'h0001;
        id_rs_ready = 1'b1;
        // Next slot is valid so RECOVER sees a live mispredicting branch it must ignore.
        if_valid    = 1'b1;
        if_pc       = 16'h0040;
        if_pred_pc  = 16'h0050;
        cyc();
        if_valid   = 1'b0;
        id_br_type = BR_B;
        id_offset  = 16'h0004;
        #1;
        total++; if (redirect_pc !== 16'h0024) $display("FAIL beqz_redirect_pc got %h exp 0024", redirect_pc); else passed++;
        total++; if (redirect !== 1'b1) $display("FAIL beqz_redirect got %h exp 1", redirect); else passed++;
        cyc();
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL recover_ignored got %h exp 0", redirect); else passed++;
        cyc();
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL flushed_slot_ignored got %h exp 0", redirect); else passed++;
        total++; if ({cnt_branch, cnt_mispred} !== {16'd3, 16'd2}) $display("FAIL beqz_counters got %h exp 00030002", {cnt_branch, cnt_mispred}); else passed++;
        id_br_type = BR_NONE;
        cyc();
    endtask

    task automatic test_cond_variants();
        // BNEZ taken, correctly predicted.
        load_slot(16'h0040, 16'h0050);
        id_br_type = BR_BNEZ;
        id_offset  = 16'h0010;
        id_rs_val  = 16'h0005;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL bnez_redirect got %h exp 0", redirect); else passed++;
        total++; if (cnt_branch !== 16'd4) $display("FAIL bnez_cnt_branch got %0d exp 4", cnt_branch); else passed++;
        cyc();
        // BEQZ taken backwards, predicted fall-through.
        load_slot(16'h0080, 16'h0084);
        id_br_type = BR_BEQZ;
        id_offset  = 16'hFFF8;
        id_rs_val  = 16'h0000;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect_pc !== 16'h0078) $display("FAIL beqz_back_pc got %h exp 0078", redirect_pc); else passed++;
        total++; if (cnt_mispred !== 16'd3) $display("FAIL beqz_back_cnt got %0d exp 3", cnt_mispred); else passed++;
        cyc();
        cyc();
        // Unknown type code behaves as no branch.
        load_slot(16'h0090, 16'h1000);
        id_br_type = 3'b111;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if ({redirect, hold_id} !== 2'b00) $display("FAIL unknown_type got %b exp 00", {redirect, hold_id}); else passed++;
        total++; if (cnt_branch !== 16'd5) $display("FAIL unknown_cnt got %0d exp 5", cnt_branch); else passed++;
        cyc();
    endtask

    task automatic test_jr_wait();
        load_slot(16'h0100, 16'h0104);
        id_br_type  = BR_JR;
        id_rs_ready = 1'b0;
        id_rs_val   = 16'h0BAD;
        if_valid    = 1'b1;
        if_pc       = 16'h0200;
        if_pred_pc  = 16'h0204;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (hold_id !== 1'b1) $display("FAIL jr_hold_%0d got %h exp 1", i, hold_id); else passed++;
            cyc();
        end
        if_valid    = 1'b0;
        id_rs_ready = 1'b1;
        id_rs_val   = 16'h1234;
        #1;
        total++; if (hold_id !== 1'b0) $display("FAIL jr_hold_release got %h exp 0", hold_id); else passed++;
        total++; if (redirect !== 1'b0) $display("FAIL jr_early_redirect got %h exp 0", redirect); else passed++;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect !== 1'b1) $display("FAIL jr_redirect got %h exp 1", redirect); else passed++;
        total++; if (redirect_pc !== 16'h1234) $display("FAIL jr_redirect_pc got %h exp 1234", redirect_pc); else passed++;
        total++; if (btb_from !== 16'h0100) $display("FAIL jr_btb_from got %h exp 0100", btb_from); else passed++;
        total++; if (cnt_branch !== 16'd6) $display("FAIL jr_cnt_branch got %0d exp 6", cnt_branch); else passed++;
        cyc();
    endtask

    task automatic test_wrap();
        load_slot(16'hFFF0, 16'h0000);
        id_br_type = BR_B;
        id_offset  = 16'h0020;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect_pc !== 16'h0010) $display("FAIL wrap_redirect_pc got %h exp 0010", redirect_pc); else passed++;
        total++; if (btb_to !== 16'h0010) $display("FAIL wrap_btb_to got %h exp 0010", btb_to); else passed++;
        cyc();
    endtask

    task automatic test_stall();
        load_slot(16'h0010, 16'h0014);
        stall      = 1'b1;
        id_br_type = BR_B;
        id_offset  = 16'h0008;
        cyc();
        #1;
        total++; if (redirect !== 1'b0) $display("FAIL stall_redirect got %h exp 0", redirect); else passed++;
        total++; if (cnt_branch !== 16'd7) $display("FAIL stall_cnt got %0d exp 7", cnt_branch); else passed++;
        stall = 1'b0;
        cyc();
        id_br_type = BR_NONE;
        #1;
        total++; if (redirect !== 1'b1) $display("FAIL unstall_redirect got %h exp 1", redirect); else passed++;
        total++; if ({cnt_branch, cnt_mispred} !== {16'd8, 16'd6}) $display("FAIL unstall_counters got %h exp 00080006", {cnt_branch, cnt_mispred}); else passed++;
        cyc();
    endtask

    task automatic test_rst_wait_op();
        load_slot(16'h0300, 16'h0304);
        id_br_type  = BR_JR;
        id_rs_ready = 1'b0;
        cyc();
        #1;
        total++; if (hold_id !== 1'b1) $display("FAIL waitop_hold got %h exp 1", hold_id); else passed++;
        rst = 1'b1;
        #1;
        total++; if (hold_id !== 1'b0) $display("FAIL async_rst_hold got %h exp 0", hold_id); else passed++;
        total++; if ({cnt_branch, cnt_mispred} !== 32'h0) $display("FAIL async_rst_counters got %h exp 0", {cnt_branch, cnt_mispred}); else passed++;
        cyc();
        rst = 1'b0;
        id_rs_ready = 1'b1;
        id_rs_val   = 16'h4444;
        #1;
        total++; if (hold_id !== 1'b0) $display("FAIL post_rst_hold got %h exp 0", hold_id); else passed++;
        cyc();
        #1;
        total++; if ({redirect, btb_upd_n} !== 2'b01) $display("FAIL post_rst_no_update got %b exp 01", {redirect, btb_upd_n}); else passed++;
        id_br_type = BR_NONE;
        cyc();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            load_slot(16'h0010, 16'h0014);
            id_br_type = BR_B;
            id_offset  = 16'h0008;
            cyc();
            id_br_type = BR_NONE;
            cyc();
            if (i == 6) begin
                #1;
                total++; if (sat_cnt_mispred !== 3'd7) $display("FAIL sat_at_max got %0d exp 7", sat_cnt_mispred); else passed++;
            end
        end
        #1;
        total++; if (sat_cnt_mispred !== 3'd7) $display("FAIL sat_mispred got %0d exp 7", sat_cnt_mispred); else passed++;
        total++; if (sat_cnt_branch !== 3'd7) $display("FAIL sat_branch got %0d exp 7", sat_cnt_branch); else passed++;
        total++; if (cnt_mispred !== 16'd9) $display("FAIL wide_mispred got %0d exp 9", cnt_mispred); else passed++;
        total++; if (cnt_branch !== 16'd9) $display("FAIL wide_branch got %0d exp 9", cnt_branch); else passed++;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        if_valid    = 1'b0;
        if_pc       = 16'h0000;
        if_pred_pc  = 16'h0000;
        id_br_type  = BR_NONE;
        id_offset   = 16'h0000;
        id_rs_val   = 16'h0000;
        id_rs_ready = 1'b1;

        test_reset();
        test_b_match();
        test_b_mispredict();
        test_beqz_recover();
        test_cond_variants();
        test_jr_wait();
        test_wrap();
        test_stall();
        test_rst_wait_op();
        test_saturation();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
